// File: rtl/conv_input_interface_if.sv
// Handshake and image-RAM bus between the conv-layer controller, the image RAM and
// the input interface. The master side is the controller/RAM, the slave side the responder.
interface conv_input_interface_if #(
  parameter int DATA_W  = 16,
  parameter int ARRAY_W = 6,
  parameter int ADDR_W  = 8
) ();
  logic [1:0]                cmd;
  logic [ADDR_W-1:0]         frame_base;
  logic [1:0]                ack;
  logic                      rd_en;
  logic [ADDR_W-1:0]         rd_addr;
  logic [DATA_W-1:0]         rd_data;
  logic [ARRAY_W*DATA_W-1:0] data_out;
  logic                      data_valid;
  logic                      err;

  modport master (
    output cmd, frame_base, rd_data,
    input  ack, rd_en, rd_addr, data_out, data_valid, err
  );

  modport slave (
    input  cmd, frame_base, rd_data,
    output ack, rd_en, rd_addr, data_out, data_valid, err
  );
endinterface

// File: rtl/conv_input_interface.sv
// Responder side of the controller handshake: decodes PRELOAD/SHIFT/LOAD, fetches image
// rows into a K-row line buffer and presents one buffered row per SHIFT.
module conv_input_interface #(
  parameter int DATA_W  = 16,
  parameter int ARRAY_W = 6,
  parameter int K       = 3,
  parameter int IMG_H   = 8,
  parameter int ADDR_W  = 8
) (
  input logic                   clk,
  input logic                   rst,
  conv_input_interface_if.slave bus
);

  localparam int ROW_W = (K > 1) ? $clog2(K) : 1;
  localparam int COL_W = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1;
  localparam int NR_W  = $clog2(IMG_H + 1);
  localparam int CNT_W = $clog2(K * ARRAY_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_DRAIN, S_ACK} state_e;
  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PRELOAD = 2'd1,
    OP_SHIFT   = 2'd2,
    OP_LOAD    = 2'd3
  } op_e;
  typedef logic [ARRAY_W-1:0][DATA_W-1:0] row_t;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              bad_q, bad_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic [ROW_W-1:0]  wr_row_q, wr_row_d;
  logic [COL_W-1:0]  wr_col_q, wr_col_d;
  logic [ROW_W-1:0]  head_q, head_d;
  logic [ROW_W-1:0]  sel_q, sel_d;
  logic [NR_W-1:0]   next_row_q, next_row_d;
  row_t              line_q [K];
  row_t              line_d [K];
  logic [1:0]        ack_q, ack_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  row_t              data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              err_q, err_d;

  op_e               cmd_op;
  logic [ROW_W:0]    idx_sum;
  logic [ROW_W-1:0]  shift_idx;
  logic [ADDR_W-1:0] load_addr;
  logic [CNT_W-1:0]  n_reads;

  always_comb begin
    cmd_op    = op_e'(bus.cmd);
    idx_sum   = {1'b0, head_q} + {1'b0, sel_q};
    shift_idx = (idx_sum >= (ROW_W+1)'(K)) ? ROW_W'(idx_sum - (ROW_W+1)'(K)) : ROW_W'(idx_sum);
    load_addr = base_q + ADDR_W'(next_row_q * ARRAY_W);
    n_reads   = (op_q == OP_PRELOAD) ? CNT_W'(K * ARRAY_W) : CNT_W'(ARRAY_W);
  end

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path can infer a latch.
    state_d      = state_q;
    op_d         = op_q;
    bad_d        = bad_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    rd_vld_d     = rd_en_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    head_d       = head_q;
    sel_d        = sel_q;
    next_row_d   = next_row_q;
    line_d       = line_q;
    ack_d        = 2'd0;
    rd_en_d      = rd_en_q;
    rd_addr_d    = rd_addr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    err_d        = err_q;

    // RAM data lands one cycle after its strobe; fill the line buffer row-major.
    if (rd_vld_q) begin
      line_d[wr_row_q][wr_col_q] = bus.rd_data;
      if (wr_col_q == COL_W'(ARRAY_W - 1)) begin
        wr_col_d = '0;
        wr_row_d = wr_row_q + ROW_W'(1);
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        op_d  = cmd_op;
        bad_d = 1'b0;
        case (cmd_op)
          OP_NONE: ;
          OP_PRELOAD: begin
            base_d    = bus.frame_base;
            rd_en_d   = 1'b1;
            rd_addr_d = bus.frame_base;
            cnt_d     = CNT_W'(1);
            wr_row_d  = '0;
            wr_col_d  = '0;
            state_d   = S_RD;
          end
          OP_SHIFT: begin
            data_out_d   = line_q[shift_idx];
            data_valid_d = 1'b1;
            ack_d        = OP_SHIFT;
            sel_d        = (sel_q == ROW_W'(K - 1)) ? '0 : sel_q + ROW_W'(1);
            state_d      = S_ACK;
          end
          OP_LOAD: begin
            if (next_row_q == NR_W'(IMG_H)) begin
              // Frame exhausted: still answer so the controller cannot deadlock.
              bad_d   = 1'b1;
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end else begin
              rd_en_d   = 1'b1;
              rd_addr_d = load_addr;
              cnt_d     = CNT_W'(1);
              wr_row_d  = head_q;
              wr_col_d  = '0;
              state_d   = S_RD;
            end
          end
        endcase
      end
      S_RD: begin
        if (cnt_q == n_reads) begin
          rd_en_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        ack_d   = op_q;
        state_d = S_ACK;
        if (op_q == OP_PRELOAD) begin
          head_d     = '0;
          sel_d      = '0;
          next_row_d = NR_W'(K);
        end else if (!bad_q) begin
          head_d     = (head_q == ROW_W'(K - 1)) ? '0 : head_q + ROW_W'(1);
          next_row_d = next_row_q + NR_W'(1);
          sel_d      = '0;
        end
      end
      S_ACK: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && cmd_op != OP_NONE) err_d = 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NONE;
      bad_q        <= 1'b0;
      base_q       <= '0;
      cnt_q        <= '0;
      rd_vld_q     <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      head_q       <= '0;
      sel_q        <= '0;
      next_row_q   <= '0;
      // NOTE: the line buffer is reset because a SHIFT straight after reset exposes it.
      line_q       <= '{default: '0};
      ack_q        <= 2'd0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      bad_q        <= bad_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      rd_vld_q     <= rd_vld_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      head_q       <= head_d;
      sel_q        <= sel_d;
      next_row_q   <= next_row_d;
      line_q       <= line_d;
      ack_q        <= ack_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.err        = err_q;

endmodule
